// File: rtl/ws2812_tx.sv
// WS2812 serial transmitter: buffers colour bytes, then streams
// them MSB first as timed high/low bit periods followed by a latch gap.
module ws2812_tx #(
  parameter int LED_CNT = 3,
  parameter int T0H     = 20,
  parameter int T0L     = 42,
  parameter int T1H     = 40,
  parameter int T1L     = 22,
  parameter int RES_CYC = 3000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  input  logic       frame_end_i,
  output logic       led_o,
  output logic       busy_o,
  output logic       overflow_o
);

  localparam int DEPTH  = LED_CNT * 3;
  localparam int TMAX_A = (T0H > T0L) ? T0H : T0L;
  localparam int TMAX_B = (T1H > T1L) ? T1H : T1L;
  localparam int TMAX_C = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TMAX   = (TMAX_C > RES_CYC) ? TMAX_C : RES_CYC;
  localparam int CW     = $clog2(TMAX + 1);
  localparam int PW     = $clog2(DEPTH + 1);
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t C_T0H = cnt_t'(T0H);
  localparam cnt_t C_T0L = cnt_t'(T0L);
  localparam cnt_t C_T1H = cnt_t'(T1H);
  localparam cnt_t C_T1L = cnt_t'(T1L);
  localparam cnt_t C_RES = cnt_t'(RES_CYC);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HIGH,
    LOW,
    LATCH
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] n_len;
  logic [IW-1:0] rd_ptr;
  logic [IW-1:0] rd_nxt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    nxt_byte;
  cnt_t          cnt;
  logic          wr_ok;
  logic          frame_go;
  logic          cnt_done;
  logic          last_bit;
  logic          last_byte;

  function automatic cnt_t hi_len(input logic b);
    return b ? C_T1H : C_T0H;
  endfunction

  function automatic cnt_t lo_len(input logic b);
    return b ? C_T1L : C_T0L;
  endfunction

  assign busy_o = (state != IDLE);

  always_comb begin
    wr_ok     = 1'b0;
    frame_go  = 1'b0;
    cnt_done  = 1'b0;
    last_bit  = 1'b0;
    last_byte = 1'b0;
    rd_nxt    = '0;
    nxt_byte  = '0;
    wr_ok     = byte_valid_i && (state == IDLE)
                && (wr_ptr < PW'(DEPTH));
    // a byte arriving with the stop strobe counts toward the frame
    frame_go  = frame_end_i && (state == IDLE)
                && ((wr_ptr != '0) || wr_ok);
    cnt_done  = (cnt <= cnt_t'(1));
    last_bit  = (bit_idx == 3'd0);
    last_byte = ((PW'(rd_ptr) + PW'(1)) == n_len);
    rd_nxt    = (rd_ptr == IW'(DEPTH - 1)) ? '0
                                           : rd_ptr + IW'(1);
    nxt_byte  = mem[rd_nxt];
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (frame_go) state_next = LOAD;
      end
      LOAD: begin
        state_next = HIGH;
      end
      HIGH: begin
        if (cnt_done) state_next = LOW;
      end
      LOW: begin
        if (cnt_done) begin
          if (last_bit && last_byte) state_next = LATCH;
          else                       state_next = HIGH;
        end
      end
      LATCH: begin
        if (cnt_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // buffer is deliberately outside reset
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) mem[wr_ptr[IW-1:0]] <= byte_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_o      <= 1'b0;
      overflow_o <= 1'b0;
      wr_ptr     <= '0;
      n_len      <= '0;
      rd_ptr     <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      cnt        <= '0;
    end else begin
      led_o <= (state == HIGH);
      if (byte_valid_i && !wr_ok) overflow_o <= 1'b1;
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      unique case (state)
        IDLE: begin
          if (frame_go) begin
            n_len  <= wr_ptr + PW'(wr_ok);
            rd_ptr <= '0;
          end
        end
        LOAD: begin
          shreg   <= mem[0];
          bit_idx <= 3'd7;
          cnt     <= hi_len(mem[0][7]);
        end
        HIGH: begin
          if (cnt_done) cnt <= lo_len(shreg[7]);
          else          cnt <= cnt - cnt_t'(1);
        end
        LOW: begin
          if (!cnt_done) begin
            cnt <= cnt - cnt_t'(1);
          end else if (!last_bit) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_idx <= bit_idx - 3'd1;
            cnt     <= hi_len(shreg[6]);
          end else if (!last_byte) begin
            // next byte prefetched so the bit stream has no gap
            rd_ptr  <= rd_nxt;
            shreg   <= nxt_byte;
            bit_idx <= 3'd7;
            cnt     <= hi_len(nxt_byte[7]);
          end else begin
            cnt <= C_RES;
          end
        end
        LATCH: begin
          if (!cnt_done) begin
            cnt <= cnt - cnt_t'(1);
          end else begin
            cnt    <= '0;
            wr_ptr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_tx.sv
// Scoreboard bench for ws2812_tx: a byte-level model predicts every
// bit pulse and frame window; a monitor decodes led_o and compares.
module tb_ws2812_tx;

  localparam int LED_CNT = 1;
  localparam int T0H     = 2;
  localparam int T0L     = 4;
  localparam int T1H     = 4;
  localparam int T1L     = 2;
  localparam int RES_CYC = 10;
  localparam int DEPTH   = LED_CNT * 3;

  typedef struct {
    int hi;
    int lo;
  } bit_t;

  typedef struct {
    int rise;
    int blen;
  } frm_t;

  logic       clk;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       frame_end;
  logic       led;
  logic       busy;
  logic       ovf_o;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  bit_t       bq[$];
  frm_t       fq[$];
  logic [7:0] pend[$];
  bit         m_ovf;

  int         hcnt;
  int         lcnt;
  int         blen_m;
  int         rise_m;
  bit         in_frame;

  ws2812_tx #(
    .LED_CNT(LED_CNT),
    .T0H    (T0H),
    .T0L    (T0L),
    .T1H    (T1H),
    .T1L    (T1L),
    .RES_CYC(RES_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .byte_i      (byte_in),
    .byte_valid_i(byte_valid),
    .frame_end_i (frame_end),
    .led_o       (led),
    .busy_o      (busy),
    .overflow_o  (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act,
                              input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                  name, act, exp, cyc);
  endfunction

  function automatic void close_bit(input int h, input int l);
    bit_t e;
    chk("bit_expected", int'(bq.size() > 0), 1);
    if (bq.size() > 0) begin
      e = bq.pop_front();
      chk("bit_high", h, e.hi);
      chk("bit_low", l, e.lo);
    end
  endfunction

  function automatic void close_frame(input int r, input int b);
    frm_t f;
    chk("frame_expected", int'(fq.size() > 0), 1);
    if (fq.size() > 0) begin
      f = fq.pop_front();
      chk("frame_rise_cyc", r, f.rise);
      chk("frame_busy_len", b, f.blen);
    end
  endfunction

  initial begin
    hcnt     = 0;
    lcnt     = 0;
    blen_m   = 0;
    rise_m   = -1;
    in_frame = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hcnt     = 0;
        lcnt     = 0;
        in_frame = 0;
        bq.delete();
        fq.delete();
      end else begin
        if (led) begin
          if (lcnt > 0) begin
            close_bit(hcnt, lcnt);
            hcnt = 0;
            lcnt = 0;
          end
          hcnt++;
        end else if (hcnt > 0) begin
          lcnt++;
        end
        if (busy && !in_frame) begin
          in_frame = 1;
          blen_m   = 0;
          rise_m   = -1;
        end
        if (in_frame && busy) blen_m++;
        if (in_frame && led && rise_m < 0) rise_m = cyc;
        if (in_frame && !busy) begin
          if (hcnt > 0) close_bit(hcnt, lcnt);
          hcnt = 0;
          lcnt = 0;
          close_frame(rise_m, blen_m);
          in_frame = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_write(input logic [7:0] b);
    if (pend.size() < DEPTH) pend.push_back(b);
    else m_ovf = 1'b1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_led", int'(led), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf_o), 0);
    #1;
    reset = 1'b0;
    pend.delete();
    m_ovf = 1'b0;
  endtask

  task automatic wr(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    model_write(b);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic do_frame(input bit wb, input logic [7:0] b,
                          input int junk_at, input bit junk_fe,
                          input int rst_at);
    int         s;
    int         sum;
    int         blen;
    int         jk;
    int         nb;
    int         nl;
    bit         abort;
    bit_t       e;
    frm_t       f;
    logic [7:0] v;
    byte_in    = b;
    byte_valid = wb;
    frame_end  = 1'b1;
    if (wb) model_write(b);
    tick();
    byte_valid = 1'b0;
    frame_end  = 1'b0;
    if (pend.size() == 0) begin
      nb = 0;
      repeat (6) begin
        tick();
        nb += int'(busy);
      end
      chk("empty_frame_busy", nb, 0);
      return;
    end
    s   = cyc;
    sum = 0;
    foreach (pend[i]) begin
      v = pend[i];
      for (int j = 7; j >= 0; j--) begin
        e.hi = v[j] ? T1H : T0H;
        e.lo = v[j] ? T1L : T0L;
        sum += e.hi + e.lo;
        if (i == pend.size() - 1 && j == 0) e.lo += RES_CYC;
        bq.push_back(e);
      end
    end
    blen   = 1 + sum + RES_CYC;
    f.rise = s + 2;
    f.blen = blen;
    fq.push_back(f);
    pend.delete();
    jk = (junk_at < 0) ? int'($urandom_range(1, blen)) : junk_at;
    abort = 1'b0;
    for (int k = 1; k <= blen; k++) begin
      if (k == rst_at) begin
        do_reset();
        abort = 1'b1;
        break;
      end
      if (k == jk) begin
        byte_in    = 8'($urandom);
        byte_valid = 1'b1;
        frame_end  = junk_fe;
        m_ovf      = 1'b1;
      end
      tick();
      byte_valid = 1'b0;
      frame_end  = 1'b0;
    end
    if (abort) begin
      nb = 0;
      nl = 0;
      repeat (RES_CYC + 4) begin
        tick();
        nb += int'(busy);
        nl += int'(led);
      end
      chk("no_latch_busy", nb, 0);
      chk("no_led_after_rst", nl, 0);
    end else begin
      chk("overflow", int'(ovf_o), int'(m_ovf));
    end
  endtask

  initial begin
    int nbytes;
    reset      = 1'b1;
    byte_in    = '0;
    byte_valid = 1'b0;
    frame_end  = 1'b0;
    m_ovf      = 1'b0;
    do_reset();

    wr(8'hA5);
    wr(8'h00);
    wr(8'hFF);
    do_frame(1'b0, 8'h00, 0, 1'b0, 0);

    wr(8'h80);
    do_frame(1'b0, 8'h00, 0, 1'b0, 0);

    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    wr(8'h44);
    chk("overflow_4th", int'(ovf_o), int'(m_ovf));
    do_frame(1'b0, 8'h00, 0, 1'b0, 0);

    do_reset();
    do_frame(1'b1, 8'h01, 0, 1'b0, 0);
    do_frame(1'b0, 8'h00, 0, 1'b0, 0);

    wr(8'hC3);
    wr(8'h5A);
    wr(8'h96);
    do_frame(1'b0, 8'h00, 0, 1'b0, 63);
    wr(8'h3C);
    do_frame(1'b0, 8'h00, 0, 1'b0, 0);

    wr(8'h0F);
    do_frame(1'b0, 8'h00, 2, 1'b1, 0);
    wr(8'hE1);
    wr(8'h7E);
    wr(8'h18);
    do_frame(1'b0, 8'h00, 0, 1'b0, 0);

    do_reset();
    repeat (25) begin
      nbytes = int'($urandom_range(0, 4));
      for (int k = 0; k < nbytes; k++) begin
        repeat (int'($urandom_range(0, 2))) tick();
        wr(8'($urandom));
      end
      do_frame(1'($urandom_range(0, 1)), 8'($urandom),
               ($urandom_range(0, 2) == 0) ? -1 : 0,
               1'($urandom_range(0, 1)), 0);
      repeat (int'($urandom_range(0, 3))) tick();
    end

    repeat (5) tick();
    chk("bits_drained", bq.size(), 0);
    chk("frames_drained", fq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ws2812_tx.md
WS2812_TX -- requirements
Module: ws2812_tx

Interface
REQ-001 The block SHALL have parameter LED_CNT, default 3, giving the number of LEDs on the chain; buffer depth is LED_CNT*3 bytes.
REQ-002 The block SHALL have parameter T0H, default 20, giving the high-phase length in clk cycles for a 0 bit.
REQ-003 The block SHALL have parameter T0L, default 42, giving the low-phase length in clk cycles for a 0 bit.
REQ-004 The block SHALL have parameter T1H, default 40, giving the high-phase length in clk cycles for a 1 bit.
REQ-005 The block SHALL have parameter T1L, default 22, giving the low-phase length in clk cycles for a 1 bit.
REQ-006 The block SHALL have parameter RES_CYC, default 3000, giving the latch/reset low time in clk cycles.
REQ-007 The block SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-009 The block SHALL have port byte_i, input, 8 bits, the colour byte delivered by the I2C slave stage.
REQ-010 The block SHALL have port byte_valid_i, input, 1 bit, a one-cycle strobe qualifying byte_i.
REQ-011 The block SHALL have port frame_end_i, input, 1 bit, a one-cycle strobe (I2C stop) requesting transmission.
REQ-012 The block SHALL have port led_o, output, 1 bit, the WS2812 serial data line.
REQ-013 The block SHALL have port busy_o, output, 1 bit, high whenever the state is not IDLE.
REQ-014 The block SHALL have port overflow_o, output, 1 bit, a sticky flag that a byte was dropped.

Function
REQ-015 The block SHALL use states IDLE, LOAD, HIGH, LOW and LATCH.
REQ-016 In IDLE, each byte_valid_i SHALL write byte_i to buf[wr_ptr] and increment wr_ptr, which runs 0..LED_CNT*3.
REQ-017 When byte_valid_i arrives with wr_ptr = LED_CNT*3, the byte SHALL be dropped and overflow_o set; there is no wrap-around.
REQ-018 A byte_valid_i outside IDLE SHALL be dropped and SHALL set overflow_o.
REQ-019 frame_end_i in IDLE with wr_ptr = 0 SHALL be ignored, and the state stays IDLE.
REQ-020 frame_end_i in IDLE with wr_ptr > 0 SHALL capture n = wr_ptr and move to LOAD.
REQ-021 If byte_valid_i and frame_end_i occur in the same IDLE cycle, the byte SHALL be written first and included in n.
REQ-022 frame_end_i outside IDLE SHALL be ignored.
REQ-023 LOAD SHALL last exactly 1 cycle and fetch buf[0]; led_o SHALL go high on the 2nd rising edge after the edge that sampled frame_end_i.
REQ-024 Bits SHALL be sent MSB first, bytes in index order 0..n-1.
REQ-025 In HIGH, led_o SHALL be 1 for exactly T1H (bit=1) or T0H (bit=0) cycles.
REQ-026 In LOW, led_o SHALL be 0 for exactly T1L or T0L cycles.
REQ-027 Bit periods SHALL be contiguous, including across byte boundaries; the next byte is prefetched with no gap cycle.
REQ-028 After the LOW phase of bit 0 of byte n-1, the block SHALL enter LATCH and hold led_o = 0 for exactly RES_CYC cycles.
REQ-029 On leaving LATCH, the block SHALL return to IDLE with wr_ptr = 0; buffer contents are retained but are no longer valid.
REQ-030 Phase counters SHALL be wide enough for max(T*, RES_CYC) and SHALL count down to 1 with no off-by-one.
REQ-031 busy_o SHALL be combinationally equal to (state != IDLE).

Reset
REQ-032 While reset is high at a rising edge, the next state SHALL be IDLE, with led_o = 0, busy_o = 0, overflow_o = 0, wr_ptr = 0 and all counters at 0.
REQ-033 Buffer contents SHALL NOT be cleared by reset.
REQ-034 Reset during HIGH, LOW or LATCH SHALL drive led_o low on the next edge, abort the frame, and send no latch.
REQ-035 overflow_o SHALL be cleared only by reset.

Verification (bench parameters: LED_CNT=1, T0H=2, T0L=4, T1H=4, T1L=2, RES_CYC=10)
REQ-036 Basic frame: write 8'hA5, 8'h00 and 8'hFF, then pulse frame_end. Required: led_o rises 2 cycles later; byte A5 is high 4/2/4/2/2/4/2/4 cycles; each bit is 6 cycles total; 24 bits take 144 cycles; then 10 low cycles; busy_o falls afterward.
REQ-037 Partial frame: write 8'h80 only, then frame_end. Required: 8 bits (high 4, then 7x high 2), then LATCH; the total busy time from LOAD is 1+48+10 cycles.
REQ-038 Overflow: write 4 bytes. Required: the 4th byte is dropped and overflow_o = 1. A frame_end then sends exactly 3 bytes, and overflow_o stays 1.
REQ-039 Simultaneous events: byte_valid=1 with 8'h01 and frame_end=1 in the same cycle with empty buffer. Required: 1 byte is sent (seven 0-bits then one 1-bit), and frame_end with an empty buffer produces no activity.
REQ-040 Reset mid-frame: assert reset during bit 5 of byte 1. Required: led_o = 0 and busy_o = 0 the next cycle, and no LATCH phase. A new write plus frame_end works normally.
REQ-041 Busy drop: byte_valid during HIGH. Required: overflow_o = 1, the transmitted bits are unchanged, and wr_ptr is 0 after LATCH.
